spi_regbank_peripheral: RTL and testbench
=========================================

# spi_regbank_peripheral

Parametrised SPI mode-0 register-bank peripheral. It is the next generation of the TT PWM SPI front end: it adds register readback on CIPO, burst transfers with address auto-increment, and configurable address width, data width and register count. All SPI pins are oversampled in the `clk` domain. The block drives a flat register vector consumed by the PWM and output-enable logic.

## Interface
Parameters:
- `ADDR_W`, 7, address field width in bits.
- `DATA_W`, 8, data word width in bits (≥2).
- `NUM_REGS`, 5, number of implemented registers (≤ 2^ADDR_W).
- `RESET_VALUES`, 0, flat `NUM_REGS*DATA_W` reset image; register i occupies bits `[i*DATA_W +: DATA_W]`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SCLK`  in  1  SPI clock, asynchronous.
- `COPI`  in  1  controller-out data, asynchronous.
- `nCS`  in  1  chip select, active-low, asynchronous.
- `CIPO`  out  1  peripheral-out data.
- `cipo_oe`  out  1  CIPO output enable; high while a transaction is active.
- `regs_out`  out  `NUM_REGS*DATA_W`  flat register contents.
- `wr_pulse`  out  1  one-clk pulse per committed write.
- `wr_addr`  out  `ADDR_W`  address of the last committed write.
- `frame_err`  out  1  one-clk pulse when a frame ends with a partial header or word.

## Operation
- **Synchronisers:** two-flop synchronisers on `SCLK`, `COPI` and `nCS`. The `nCS` flops reset to 1 and the others reset to 0.
  - Edges come from the synchronised value plus a one-clk delayed copy: `sclk_rise`, `sclk_fall`, `ncs_fall`, `ncs_rise`.
- **Frame format:** bit 0 is R/W (1 = write, 0 = read). Next come `ADDR_W` address bits, MSB first. Then one or more `DATA_W`-bit words, MSB first. Controller samples on SCLK rising edge; peripheral shifts on falling edge.
- **FSM:** states IDLE, HDR, DATA.
  - IDLE → HDR on `ncs_fall`; clears the bit counter and the shift register.
  - HDR: each `sclk_rise` shifts in `COPI_sync`. After 1+`ADDR_W` bits, latch `rw` and `addr`, then go to DATA.
  - DATA: each `sclk_rise` shifts into `wdata`. On the `DATA_W`th bit of a word, the word completes:
    - Write: if `addr < NUM_REGS`, load the register next clk, pulse `wr_pulse`, set `wr_addr = addr`. Otherwise discard with no pulse.
    - Both read and write: `addr <= addr + 1`, wrapping modulo 2^`ADDR_W`. The word counter returns to 0.
  - Any state → IDLE on `ncs_rise`. If in HDR with ≥1 bit counted, or in DATA with ≥1 bit of the current word counted, pulse `frame_err`. Partial words never commit.
- **Readback:**
  - On the header-completing `sclk_rise` (read frame), and on each word-completing `sclk_rise` in DATA, load `rdata` with `reg[addr_next]`. Out-of-range addresses read as 0.
  - `CIPO = rdata[DATA_W-1]`. On each `sclk_fall` in DATA, `rdata` shifts left by 1 with 0 fill.
  - For a write frame, `rdata` is loaded the same way, so CIPO echoes the old contents.
  - In IDLE, `CIPO = 0` and `cipo_oe = 0`.
- **Priority within one clk:** `ncs_rise` beats `sclk_rise`/`sclk_fall`; that SCLK edge is ignored. `ncs_fall` while not in IDLE (glitch) restarts HDR.
- **Reset:**
  - `regs_out = RESET_VALUES`; `CIPO`, `cipo_oe`, `wr_pulse`, `frame_err` = 0; `wr_addr` = 0; FSM = IDLE.
  - Reset asserted mid-frame aborts the frame without committing. A fresh `ncs_fall` is required after release.

## Timing
- Edge detect latency is 3 clk from a pin edge to `sclk_rise`/`ncs_fall` being visible. `COPI` is sampled through the same pipeline depth, so it is aligned with `sclk_rise`.
- A register update is visible on `regs_out` and `wr_pulse` 1 clk after the word-completing `sclk_rise`, i.e. 4 clk after the pin edge.
- CIPO updates 1 clk after `sclk_fall`/load, i.e. ≤4 clk after the SCLK pin edge.
- Constraints:
  - SCLK high and low times are each ≥ 6 clk periods.
  - `nCS` setup to the first SCLK rise is ≥ 4 clk, and hold after the last SCLK fall is ≥ 4 clk.
- Back-to-back frames need `nCS` high for ≥ 4 clk.

## Test plan
Default parameters are used unless noted.
- **Write:** frame 1,0x02,0xA5 → `reg[2] = 0xA5`; one `wr_pulse`; `wr_addr = 2`; other registers unchanged.
- **Burst write:** 1,0x01,0x11,0x22,0x33 → `reg[1..3] = 0x11,0x22,0x33`; three `wr_pulse`s; `frame_err = 0`.
- **Readback:** after the burst, frame 0,0x01 followed by 16 clocks → CIPO bits decode to 0x11 then 0x22. A read of addr 0x7F returns 0x00, then wraps to addr 0 on the next word.
- **Abort:** 1,0x04,then 5 data bits with nCS high → `reg[4]` unchanged; `frame_err` pulses once; no `wr_pulse`. An out-of-range write to 0x05 gives no pulse and no change.
- **Reset:** reset asserted mid-word → `regs_out = RESET_VALUES`, `cipo_oe = 0`. A full frame after release works.
- **Parameters:** `ADDR_W=4`, `DATA_W=16`, `NUM_REGS=3`; write 1,0x2,0xBEEF, then read it back → `reg[2] = 0xBEEF`; CIPO returns 0xBEEF.

Source files
------------

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 register bank peripheral: oversampled pins, R/W + address header,
// burst data words with address auto-increment and register readback on CIPO.
module spi_regbank_peripheral #(
   parameter int unsigned                ADDR_W       = 7,
   parameter int unsigned                DATA_W       = 8,
   parameter int unsigned                NUM_REGS     = 5,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = {(NUM_REGS*DATA_W){1'b0}}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       SCLK,
   input  logic                       COPI,
   input  logic                       nCS,
   output logic                       CIPO,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic                       wr_pulse,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       frame_err
);

   localparam int unsigned     HDR_BITS   = ADDR_W + 1;
   localparam int unsigned     MAX_BITS   = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
   localparam int unsigned     CNT_W      = $clog2(MAX_BITS + 1);
   localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   logic [2:0]                 sclk_sync_q;
   logic [2:0]                 ncs_sync_q;
   logic [1:0]                 copi_sync_q;
   state_e                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [ADDR_W-1:0]          hdr_q, hdr_d;
   logic                       rw_q, rw_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic [DATA_W-1:0]          wdata_q, wdata_d;
   logic [DATA_W-1:0]          rdata_q, rdata_d;
   logic [NUM_REGS*DATA_W-1:0] regs_q;
   logic                       wr_pulse_q;
   logic [ADDR_W-1:0]          wr_addr_q;
   logic                       frame_err_q, frame_err_d;
   logic                       cipo_oe_q;

   logic                       sclk_rise_s, sclk_fall_s, ncs_fall_s, ncs_rise_s, copi_s;
   logic [ADDR_W:0]            hdr_full_s;
   logic [DATA_W-1:0]          wdata_full_s;
   logic [ADDR_W-1:0]          rd_addr_s;
   logic [DATA_W-1:0]          rd_word_s;
   logic                       addr_in_range_s;
   logic                       wr_en_s;

   // Two-flop synchronisers plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= 3'b000;
         ncs_sync_q  <= 3'b111;
         copi_sync_q <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
         ncs_sync_q  <= {ncs_sync_q[1:0], nCS};
         copi_sync_q <= {copi_sync_q[0], COPI};
      end
   end

   assign sclk_rise_s     = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall_s     = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ncs_fall_s      = ~ncs_sync_q[1] & ncs_sync_q[2];
   assign ncs_rise_s      = ncs_sync_q[1] & ~ncs_sync_q[2];
   assign copi_s          = copi_sync_q[1];
   assign hdr_full_s      = {hdr_q, copi_s};
   assign wdata_full_s    = {wdata_q[DATA_W-2:0], copi_s};
   assign addr_in_range_s = ({1'b0, addr_q} < NUM_REGS_L);
   // Header completion reads the freshly decoded address; word completion reads the next one
   assign rd_addr_s       = (state_q == ST_HDR) ? hdr_full_s[ADDR_W-1:0] : (addr_q + ADDR_W'(1));

   // Readback mux; unimplemented addresses read as zero
   always_comb begin
      rd_word_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr_s == ADDR_W'(i)) begin
            rd_word_s = regs_q[i*DATA_W +: DATA_W];
         end else begin
            rd_word_s = rd_word_s;
         end
      end
   end

   // Frame FSM next-state, shift registers and commit strobe
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hdr_d       = hdr_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      frame_err_d = 1'b0;
      wr_en_s     = 1'b0;
      if (ncs_rise_s) begin
         state_d     = ST_IDLE;
         frame_err_d = (state_q != ST_IDLE) && (cnt_q != CNT_W'(0));
         cnt_d       = CNT_W'(0);
         rdata_d     = {DATA_W{1'b0}};
      end else if (ncs_fall_s) begin
         state_d = ST_HDR;
         cnt_d   = CNT_W'(0);
         hdr_d   = {ADDR_W{1'b0}};
         wdata_d = {DATA_W{1'b0}};
         rdata_d = {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_HDR: begin
               if (sclk_rise_s) begin
                  hdr_d = hdr_full_s[ADDR_W-1:0];
                  if (cnt_q == CNT_W'(ADDR_W)) begin
                     rw_d    = hdr_full_s[ADDR_W];
                     addr_d  = hdr_full_s[ADDR_W-1:0];
                     cnt_d   = CNT_W'(0);
                     rdata_d = rd_word_s;
                     state_d = ST_DATA;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  state_d = ST_HDR;
               end
            end
            ST_DATA: begin
               if (sclk_rise_s) begin
                  wdata_d = wdata_full_s;
                  if (cnt_q == CNT_W'(DATA_W - 1)) begin
                     wr_en_s = rw_q && addr_in_range_s;
                     addr_d  = addr_q + ADDR_W'(1);
                     cnt_d   = CNT_W'(0);
                     rdata_d = rd_word_s;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (sclk_fall_s && (cnt_q != CNT_W'(0))) begin
                  // The fall right after a load keeps the MSB on CIPO for the first sample
                  rdata_d = {rdata_q[DATA_W-2:0], 1'b0};
               end else begin
                  rdata_d = rdata_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // FSM and datapath state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_W'(0);
         hdr_q   <= {ADDR_W{1'b0}};
         rw_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Register bank and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q      <= RESET_VALUES;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= {ADDR_W{1'b0}};
         frame_err_q <= 1'b0;
         cipo_oe_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_s && (addr_q == ADDR_W'(i))) begin
               regs_q[i*DATA_W +: DATA_W] <= wdata_full_s;
            end
         end
         wr_pulse_q  <= wr_en_s;
         wr_addr_q   <= wr_en_s ? addr_q : wr_addr_q;
         frame_err_q <= frame_err_d;
         cipo_oe_q   <= (state_d != ST_IDLE);
      end
   end

   assign CIPO      = rdata_q[DATA_W-1];
   assign cipo_oe   = cipo_oe_q;
   assign regs_out  = regs_q;
   assign wr_pulse  = wr_pulse_q;
   assign wr_addr   = wr_addr_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regbank_peripheral.sv
// Bench for spi_regbank_peripheral: default-width instance driven from a vector
// table with a write scoreboard, plus a 4/16/3 instance for the wide-word case.
module tb_spi_regbank_peripheral;

   localparam int          NR0 = 5;
   localparam logic [39:0] RV0 = 40'h44_03_02_01_5A;
   localparam int          H   = 8;

   logic        clk, rst_n;
   logic        sclk0, copi0, ncs0, cipo0, oe0, wrp0, ferr0;
   logic [39:0] regs0;
   logic [6:0]  wra0;
   logic        sclk1, copi1, ncs1, cipo1, oe1, wrp1, ferr1;
   logic [47:0] regs1;
   logic [3:0]  wra1;

   spi_regbank_peripheral #(.RESET_VALUES(RV0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk0), .COPI(copi0), .nCS(ncs0),
      .CIPO(cipo0), .cipo_oe(oe0), .regs_out(regs0), .wr_pulse(wrp0),
      .wr_addr(wra0), .frame_err(ferr0));

   spi_regbank_peripheral #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .SCLK(sclk1), .COPI(copi1), .nCS(ncs1),
      .CIPO(cipo1), .cipo_oe(oe1), .regs_out(regs1), .wr_pulse(wrp1),
      .wr_addr(wra1), .frame_err(ferr1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      int         nw;
      logic [7:0] w0, w1, w2;
      logic [7:0] e0, e1, e2;
      int         np;
   } vec_t;

   wr_t  exp_wr0_q[$];
   wr_t  exp_wr1_q[$];
   wr_t  e0, e1;
   int   n_vec = 0;
   int   n_err = 0;
   int   wr_cnt0 = 0, wr_cnt1 = 0, fe_cnt0 = 0, fe_cnt1 = 0;
   vec_t vt[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int sel, input logic s, input logic c, input logic n);
      if (sel == 0) begin
         sclk0 = s; copi0 = c; ncs0 = n;
      end else begin
         sclk1 = s; copi1 = c; ncs1 = n;
      end
   endtask

   task automatic cs_low(input int sel);
      drive(sel, 1'b0, 1'b0, 1'b0);
      wait_clk(6);
   endtask

   task automatic cs_high(input int sel);
      wait_clk(6);
      drive(sel, 1'b0, 1'b0, 1'b1);
      wait_clk(8);
   endtask

   // Mode 0: COPI set while SCLK low, CIPO captured at the rising pin edge
   task automatic send_bits(input int sel, input logic [127:0] bits, input int n,
                            output logic [127:0] rx);
      rx = '0;
      for (int k = n - 1; k >= 0; k--) begin
         drive(sel, 1'b0, bits[k], 1'b0);
         wait_clk(H);
         drive(sel, 1'b1, bits[k], 1'b0);
         rx[k] = (sel == 0) ? cipo0 : cipo1;
         wait_clk(H);
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   // Write scoreboard: every wr_pulse pops the expected address/data
   always @(negedge clk) begin
      if (rst_n && wrp0) begin
         wr_cnt0++;
         check("wr0 expected", 64'(exp_wr0_q.size() > 0), 64'd1);
         if (exp_wr0_q.size() > 0) begin
            e0 = exp_wr0_q.pop_front();
            check("wr0 addr", 64'(wra0), 64'(e0.addr));
            check("wr0 data", 64'(regs0[int'(e0.addr)*8 +: 8]), 64'(e0.data[7:0]));
         end
      end
      if (rst_n && wrp1) begin
         wr_cnt1++;
         check("wr1 expected", 64'(exp_wr1_q.size() > 0), 64'd1);
         if (exp_wr1_q.size() > 0) begin
            e1 = exp_wr1_q.pop_front();
            check("wr1 addr", 64'(wra1), 64'(e1.addr));
            check("wr1 data", 64'(regs1[int'(e1.addr)*16 +: 16]), 64'(e1.data));
         end
      end
      if (rst_n && ferr0) fe_cnt0++;
      if (rst_n && ferr1) fe_cnt1++;
   end

   initial begin
      logic [127:0] bits, rx, tmp;
      logic [7:0]   wv[3];
      logic [7:0]   ev[3];
      int           a, n, pc, fc;

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b1);
      drive(1, 1'b0, 1'b0, 1'b1);

      //       rw    addr   nw  w0     w1     w2     e0     e1     e2     np
      vt[0] = '{1'b1, 7'h02, 1, 8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 1};
      vt[1] = '{1'b1, 7'h01, 3, 8'h11, 8'h22, 8'h33, 8'h01, 8'hA5, 8'h03, 3};
      vt[2] = '{1'b0, 7'h01, 2, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 0};
      vt[3] = '{1'b0, 7'h7F, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 0};
      vt[4] = '{1'b1, 7'h05, 1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0};
      vt[5] = '{1'b0, 7'h03, 3, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00, 0};
      vt[6] = '{1'b1, 7'h7F, 2, 8'h99, 8'h66, 8'h00, 8'h00, 8'h5A, 8'h00, 1};
      vt[7] = '{1'b0, 7'h00, 1, 8'h00, 8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 0};

      wait_clk(3);
      check("rst regs0", 64'(regs0), 64'(RV0));
      check("rst regs1", 64'(regs1), 64'd0);
      check("rst cipo", 64'({cipo0, cipo1}), 64'd0);
      check("rst oe", 64'({oe0, oe1}), 64'd0);
      check("rst wr_pulse", 64'({wrp0, wrp1}), 64'd0);
      check("rst wr_addr", 64'({wra0, wra1}), 64'd0);
      check("rst frame_err", 64'({ferr0, ferr1}), 64'd0);
      rst_n = 1'b1;
      wait_clk(5);

      for (int i = 0; i < 8; i++) begin
         wv[0] = vt[i].w0; wv[1] = vt[i].w1; wv[2] = vt[i].w2;
         ev[0] = vt[i].e0; ev[1] = vt[i].e1; ev[2] = vt[i].e2;
         bits = '0;
         bits[7:0] = {vt[i].rw, vt[i].addr};
         n = 8;
         a = int'(vt[i].addr);
         for (int k = 0; k < vt[i].nw; k++) begin
            bits = (bits << 8) | 128'(wv[k]);
            n += 8;
            if (vt[i].rw && a < NR0) exp_wr0_q.push_back('{7'(a), 16'(wv[k])});
            a = (a + 1) % 128;
         end
         pc = wr_cnt0;
         fc = fe_cnt0;
         cs_low(0);
         send_bits(0, bits, n, rx);
         cs_high(0);
         for (int k = 0; k < vt[i].nw; k++) begin
            tmp = rx >> ((vt[i].nw - 1 - k) * 8);
            check($sformatf("v%0d cipo word%0d", i, k), 64'(tmp[7:0]), 64'(ev[k]));
         end
         check($sformatf("v%0d wr_pulse count", i), 64'(wr_cnt0 - pc), 64'(vt[i].np));
         check($sformatf("v%0d pending writes", i), 64'(exp_wr0_q.size()), 64'd0);
         check($sformatf("v%0d frame_err", i), 64'(fe_cnt0 - fc), 64'd0);
      end
      check("table regs0", 64'(regs0), 64'h44_33_22_11_66);

      // Abort mid-word: no commit, one frame_err
      pc = wr_cnt0;
      fc = fe_cnt0;
      cs_low(0);
      check("oe active", 64'(oe0), 64'd1);
      send_bits(0, 128'({1'b1, 7'h04, 5'b10101}), 13, rx);
      cs_high(0);
      check("oe idle", 64'(oe0), 64'd0);
      check("cipo idle", 64'(cipo0), 64'd0);
      check("abort frame_err", 64'(fe_cnt0 - fc), 64'd1);
      check("abort wr_pulse", 64'(wr_cnt0 - pc), 64'd0);
      check("abort reg4", 64'(regs0[39:32]), 64'h44);

      // Abort inside the header
      fc = fe_cnt0;
      cs_low(0);
      send_bits(0, 128'(3'b101), 3, rx);
      cs_high(0);
      check("hdr abort frame_err", 64'(fe_cnt0 - fc), 64'd1);

      // Reset mid-word, then a full frame after release
      pc = wr_cnt0;
      cs_low(0);
      send_bits(0, 128'({1'b1, 7'h00, 3'b111}), 11, rx);
      rst_n = 1'b0;
      ncs0 = 1'b1;
      wait_clk(2);
      check("midrst regs0", 64'(regs0), 64'(RV0));
      check("midrst oe", 64'(oe0), 64'd0);
      check("midrst cipo", 64'(cipo0), 64'd0);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(8);
      check("postrst oe", 64'(oe0), 64'd0);
      check("postrst regs0", 64'(regs0), 64'(RV0));
      check("postrst wr_pulse", 64'(wr_cnt0 - pc), 64'd0);
      exp_wr0_q.push_back('{7'h02, 16'h00C3});
      cs_low(0);
      send_bits(0, 128'({1'b1, 7'h02, 8'hC3}), 16, rx);
      cs_high(0);
      check("postrst echo", 64'(rx[7:0]), 64'h02);
      cs_low(0);
      send_bits(0, 128'({1'b0, 7'h02, 8'h00}), 16, rx);
      cs_high(0);
      check("postrst readback", 64'(rx[7:0]), 64'hC3);
      check("postrst pending", 64'(exp_wr0_q.size()), 64'd0);

      // Wide instance: 4-bit address, 16-bit words
      exp_wr1_q.push_back('{7'h02, 16'hBEEF});
      cs_low(1);
      send_bits(1, 128'({1'b1, 4'h2, 16'hBEEF}), 21, rx);
      cs_high(1);
      check("w16 echo", 64'(rx[15:0]), 64'h0000);
      check("w16 reg2", 64'(regs1[47:32]), 64'hBEEF);
      check("w16 wr count", 64'(wr_cnt1), 64'd1);
      cs_low(1);
      send_bits(1, 128'({1'b0, 4'h2, 32'h0}), 37, rx);
      cs_high(1);
      check("w16 readback", 64'(rx[31:16]), 64'hBEEF);
      check("w16 oob read", 64'(rx[15:0]), 64'h0000);
      check("w16 frame_err", 64'(fe_cnt1), 64'd0);
      check("w16 pending", 64'(exp_wr1_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
